// File: rtl/fetch_pkg.sv
// Shared types and constants for the IF stage.
//   fetch_state_t     : instruction-memory handshake FSM states
//   RESET_PC_DEFAULT  : default PCF value after reset
//   NOP_INSTR_DEFAULT : default instruction placed in IF/ID on reset/flush/bubble
//   PC_INC            : sequential fetch increment
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    DROP  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INC            = 32'd4;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with a one-entry skid buffer.
// Ports:
//   clk, reset      : clock, async active-low reset
//   stall           : hold IF/ID (new data goes to the skid)
//   flush           : clear IF/ID and the skid (wins over stall)
//   load            : accepted fetch data is presented on instr_in/pc_plus4_in
//   skid_clr        : redirect in progress, skid contents are wrong-path
//   instr_out, pc_plus4_out, valid_out : decode-stage outputs
//   skid_full       : skid holds an instruction; upstream must not accept more
module if_id_reg import fetch_pkg::*; #(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        load,
  input  logic        skid_clr,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_plus4_in,
  output logic [31:0] instr_out,
  output logic [31:0] pc_plus4_out,
  output logic        valid_out,
  output logic        skid_full
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        valid_q, valid_d;
  logic        skid_full_q, skid_full_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_plus4_q, skid_pc_plus4_d;

  always_comb begin
    instr_d         = instr_q;
    pc_plus4_d      = pc_plus4_q;
    valid_d         = valid_q;
    skid_full_d     = skid_full_q;
    skid_instr_d    = skid_instr_q;
    skid_pc_plus4_d = skid_pc_plus4_q;

    if (flush) begin
      instr_d     = NOP_INSTR;
      pc_plus4_d  = '0;
      valid_d     = 1'b0;
      skid_full_d = 1'b0;
    end else if (stall) begin
      if (skid_clr) begin
        skid_full_d = 1'b0;
      end else if (load) begin
        skid_instr_d    = instr_in;
        skid_pc_plus4_d = pc_plus4_in;
        skid_full_d     = 1'b1;
      end
    end else if (skid_full_q && !skid_clr) begin
      // Upstream cannot accept while the skid is full, so load is never set here.
      instr_d     = skid_instr_q;
      pc_plus4_d  = skid_pc_plus4_q;
      valid_d     = 1'b1;
      skid_full_d = 1'b0;
    end else if (load) begin
      instr_d     = instr_in;
      pc_plus4_d  = pc_plus4_in;
      valid_d     = 1'b1;
      skid_full_d = 1'b0;
    end else begin
      // Nothing arrived: hand decode a bubble rather than repeat the old word.
      instr_d     = NOP_INSTR;
      pc_plus4_d  = '0;
      valid_d     = 1'b0;
      skid_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_q         <= NOP_INSTR;
      pc_plus4_q      <= '0;
      valid_q         <= 1'b0;
      skid_full_q     <= 1'b0;
      skid_instr_q    <= '0;
      skid_pc_plus4_q <= '0;
    end else begin
      instr_q         <= instr_d;
      pc_plus4_q      <= pc_plus4_d;
      valid_q         <= valid_d;
      skid_full_q     <= skid_full_d;
      skid_instr_q    <= skid_instr_d;
      skid_pc_plus4_q <= skid_pc_plus4_d;
    end
  end

  assign instr_out    = instr_q;
  assign pc_plus4_out = pc_plus4_q;
  assign valid_out    = valid_q;
  assign skid_full    = skid_full_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, instruction-memory req/ready handshake FSM and IF/ID.
// Ports:
//   clk, reset                 : clock, async active-low reset
//   StallF, StallD, FlushD     : hazard-unit controls
//   PCSrcD, PCBranchD          : fetch redirect
//   imem_req/addr/ready/rdata  : instruction memory handshake
//   PCF                        : current fetch PC
//   InstrD, PCPlus4D, ValidD   : decode-stage outputs
//   FetchBusy                  : request outstanding (WAIT or DROP)
//
// state | meaning
// IDLE  | one cycle after reset, no request
// FETCH | request at PCF when allowed; zero-wait accept advances PCF
// WAIT  | request held at PCF until imem_ready
// DROP  | request held, returning data is wrong-path, then jump to redirect_q
module fetch_stage import fetch_pkg::*; #(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcD,
  input  logic [31:0] PCBranchD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PCF,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic        FetchBusy
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pcf_q, pcf_d;
  logic [31:0]  redirect_q, redirect_d;
  logic [31:0]  pc_plus4;
  logic         skid_full;
  logic         load;
  logic         skid_clr;

  assign pc_plus4 = pcf_q + PC_INC;

  always_comb begin
    imem_req = 1'b0;
    unique case (state_q)
      IDLE:        imem_req = 1'b0;
      FETCH:       imem_req = !StallF && !skid_full;
      WAIT, DROP:  imem_req = 1'b1;
      default:     imem_req = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pcf_d      = pcf_q;
    redirect_d = redirect_q;
    load       = 1'b0;
    skid_clr   = 1'b0;

    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (PCSrcD) begin
          pcf_d    = PCBranchD;
          skid_clr = 1'b1;
        end
      end
      FETCH, WAIT: begin
        if (imem_req && imem_ready) begin
          state_d = FETCH;
          if (PCSrcD) begin
            pcf_d    = PCBranchD;
            skid_clr = 1'b1;
          end else begin
            load  = 1'b1;
            pcf_d = pc_plus4;
          end
        end else if (imem_req) begin
          // A presented request must stay put until accepted, so a redirect
          // here is parked in redirect_q and applied once the memory answers.
          if (PCSrcD) begin
            redirect_d = PCBranchD;
            skid_clr   = 1'b1;
            state_d    = DROP;
          end else begin
            state_d = WAIT;
          end
        end else if (PCSrcD) begin
          pcf_d    = PCBranchD;
          skid_clr = 1'b1;
        end
      end
      DROP: begin
        skid_clr = 1'b1;
        if (imem_ready) begin
          state_d = FETCH;
          pcf_d   = PCSrcD ? PCBranchD : redirect_q;
        end else if (PCSrcD) begin
          redirect_d = PCBranchD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      pcf_q      <= RESET_PC;
      redirect_q <= '0;
    end else begin
      state_q    <= state_d;
      pcf_q      <= pcf_d;
      redirect_q <= redirect_d;
    end
  end

  if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id_reg (
    .clk          (clk),
    .reset        (reset),
    .stall        (StallD),
    .flush        (FlushD),
    .load         (load),
    .skid_clr     (skid_clr),
    .instr_in     (imem_rdata),
    .pc_plus4_in  (pc_plus4),
    .instr_out    (InstrD),
    .pc_plus4_out (PCPlus4D),
    .valid_out    (ValidD),
    .skid_full    (skid_full)
  );

  assign imem_addr = pcf_q;
  assign PCF       = pcf_q;
  assign FetchBusy = (state_q == WAIT) || (state_q == DROP);

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallF, StallD, FlushD, PCSrcD;
  logic [31:0] PCBranchD;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] PCF, InstrD, PCPlus4D;
  logic        ValidD, FetchBusy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Memory returns the address as the instruction word.
  assign imem_rdata = imem_addr;

  fetch_stage dut (
    .clk        (clk),
    .reset      (reset),
    .StallF     (StallF),
    .StallD     (StallD),
    .FlushD     (FlushD),
    .PCSrcD     (PCSrcD),
    .PCBranchD  (PCBranchD),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .PCF        (PCF),
    .InstrD     (InstrD),
    .PCPlus4D   (PCPlus4D),
    .ValidD     (ValidD),
    .FetchBusy  (FetchBusy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
    PCSrcD = 1'b0; PCBranchD = '0; imem_ready = 1'b1;
    #2;
    checks++; if (PCF !== 32'h0) begin errors++; $display("FAIL rst_pcf: got %h want %h", PCF, 32'h0); end
    checks++; if (InstrD !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h want %h", InstrD, 32'h0); end
    checks++; if (PCPlus4D !== 32'h0) begin errors++; $display("FAIL rst_pc4: got %h want %h", PCPlus4D, 32'h0); end
    checks++; if (ValidD !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", ValidD); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", imem_req); end
    checks++; if (FetchBusy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", FetchBusy); end
    tick; tick;
    reset = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL idle_req: got %b want 0", imem_req); end
  endtask

  task automatic test_sequential;
    tick;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL seq_req0: got %b want 1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL seq_addr0: got %h want %h", imem_addr, 32'h0); end
    checks++; if (ValidD !== 1'b0) begin errors++; $display("FAIL seq_valid0: got %b want 0", ValidD); end
    tick;
    checks++; if (PCF !== 32'h4) begin errors++; $display("FAIL seq_pcf1: got %h want %h", PCF, 32'h4); end
    checks++; if (InstrD !== 32'h0) begin errors++; $display("FAIL seq_instr1: got %h want %h", InstrD, 32'h0); end
    checks++; if (PCPlus4D !== 32'h4) begin errors++; $display("FAIL seq_pc4_1: got %h want %h", PCPlus4D, 32'h4); end
    checks++; if (ValidD !== 1'b1) begin errors++; $display("FAIL seq_valid1: got %b want 1", ValidD); end
    tick;
    checks++; if (PCF !== 32'h8) begin errors++; $display("FAIL seq_pcf2: got %h want %h", PCF, 32'h8); end
    checks++; if (InstrD !== 32'h4) begin errors++; $display("FAIL seq_instr2: got %h want %h", InstrD, 32'h4); end
  endtask

  task automatic test_wait;
    imem_ready = 1'b0;
    #1;
    checks++; if (FetchBusy !== 1'b0) begin errors++; $display("FAIL wait_busy_pre: got %b want 0", FetchBusy); end
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++; if (FetchBusy !== 1'b1) begin errors++; $display("FAIL wait_busy%0d: got %b want 1", i, FetchBusy); end
      checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL wait_addr%0d: got %h want %h", i, imem_addr, 32'h8); end
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL wait_req%0d: got %b want 1", i, imem_req); end
    end
    imem_ready = 1'b1;
    tick;
    checks++; if (FetchBusy !== 1'b0) begin errors++; $display("FAIL wait_busy_post: got %b want 0", FetchBusy); end
    checks++; if (InstrD !== 32'h8) begin errors++; $display("FAIL wait_instr: got %h want %h", InstrD, 32'h8); end
    checks++; if (PCPlus4D !== 32'hC) begin errors++; $display("FAIL wait_pc4: got %h want %h", PCPlus4D, 32'hC); end
    checks++; if (PCF !== 32'hC) begin errors++; $display("FAIL wait_pcf: got %h want %h", PCF, 32'hC); end
  endtask

  task automatic test_stall_skid;
    StallD = 1'b1;
    tick;
    checks++; if (PCF !== 32'h10) begin errors++; $display("FAIL skid_pcf: got %h want %h", PCF, 32'h10); end
    checks++; if (InstrD !== 32'h8) begin errors++; $display("FAIL skid_hold1: got %h want %h", InstrD, 32'h8); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL skid_req1: got %b want 0", imem_req); end
    tick;
    checks++; if (InstrD !== 32'h8) begin errors++; $display("FAIL skid_hold2: got %h want %h", InstrD, 32'h8); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL skid_req2: got %b want 0", imem_req); end
    StallD = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL skid_req_drain: got %b want 0", imem_req); end
    tick;
    checks++; if (InstrD !== 32'hC) begin errors++; $display("FAIL skid_instr: got %h want %h", InstrD, 32'hC); end
    checks++; if (PCPlus4D !== 32'h10) begin errors++; $display("FAIL skid_pc4: got %h want %h", PCPlus4D, 32'h10); end
    checks++; if (ValidD !== 1'b1) begin errors++; $display("FAIL skid_valid: got %b want 1", ValidD); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL skid_req3: got %b want 1", imem_req); end
    checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL skid_addr: got %h want %h", imem_addr, 32'h10); end
  endtask

  task automatic test_redirect_drop;
    imem_ready = 1'b0;
    tick;
    checks++; if (FetchBusy !== 1'b1) begin errors++; $display("FAIL drop_busy_wait: got %b want 1", FetchBusy); end
    PCSrcD = 1'b1; PCBranchD = 32'h100;
    tick;
    PCSrcD = 1'b0; PCBranchD = 32'h0;
    checks++; if (FetchBusy !== 1'b1) begin errors++; $display("FAIL drop_busy: got %b want 1", FetchBusy); end
    checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL drop_addr: got %h want %h", imem_addr, 32'h10); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL drop_req: got %b want 1", imem_req); end
    imem_ready = 1'b1;
    tick;
    checks++; if (PCF !== 32'h100) begin errors++; $display("FAIL drop_pcf: got %h want %h", PCF, 32'h100); end
    checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL drop_next_addr: got %h want %h", imem_addr, 32'h100); end
    checks++; if (InstrD === 32'h10) begin errors++; $display("FAIL drop_discard: got %h want not %h", InstrD, 32'h10); end
    tick;
    checks++; if (InstrD !== 32'h100) begin errors++; $display("FAIL drop_instr: got %h want %h", InstrD, 32'h100); end
    checks++; if (PCPlus4D !== 32'h104) begin errors++; $display("FAIL drop_pc4: got %h want %h", PCPlus4D, 32'h104); end
    checks++; if (ValidD !== 1'b1) begin errors++; $display("FAIL drop_valid: got %b want 1", ValidD); end
  endtask

  task automatic test_flush_stall;
    StallF = 1'b1; FlushD = 1'b1; StallD = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stallf_req: got %b want 0", imem_req); end
    tick;
    checks++; if (InstrD !== 32'h0) begin errors++; $display("FAIL flush_instr: got %h want %h", InstrD, 32'h0); end
    checks++; if (ValidD !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", ValidD); end
    checks++; if (PCPlus4D !== 32'h0) begin errors++; $display("FAIL flush_pc4: got %h want %h", PCPlus4D, 32'h0); end
    checks++; if (PCF !== 32'h104) begin errors++; $display("FAIL stallf_pcf: got %h want %h", PCF, 32'h104); end
    StallF = 1'b0; FlushD = 1'b0; StallD = 1'b0;
  endtask

  task automatic test_redirect_fetch;
    PCSrcD = 1'b1; PCBranchD = 32'h200;
    tick;
    PCSrcD = 1'b0; PCBranchD = 32'h0;
    checks++; if (PCF !== 32'h200) begin errors++; $display("FAIL redir_pcf: got %h want %h", PCF, 32'h200); end
    checks++; if (InstrD === 32'h104) begin errors++; $display("FAIL redir_discard: got %h want not %h", InstrD, 32'h104); end
    tick;
    checks++; if (InstrD !== 32'h200) begin errors++; $display("FAIL redir_instr: got %h want %h", InstrD, 32'h200); end
    checks++; if (PCF !== 32'h204) begin errors++; $display("FAIL redir_pcf2: got %h want %h", PCF, 32'h204); end
  endtask

  task automatic test_reset_mid_wait;
    imem_ready = 1'b0; StallD = 1'b1;
    tick;
    checks++; if (FetchBusy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b want 1", FetchBusy); end
    checks++; if (InstrD !== 32'h200) begin errors++; $display("FAIL mid_hold: got %h want %h", InstrD, 32'h200); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (PCF !== 32'h0) begin errors++; $display("FAIL mid_pcf: got %h want %h", PCF, 32'h0); end
    checks++; if (InstrD !== 32'h0) begin errors++; $display("FAIL mid_instr: got %h want %h", InstrD, 32'h0); end
    checks++; if (PCPlus4D !== 32'h0) begin errors++; $display("FAIL mid_pc4: got %h want %h", PCPlus4D, 32'h0); end
    checks++; if (ValidD !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", ValidD); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL mid_req: got %b want 0", imem_req); end
    checks++; if (FetchBusy !== 1'b0) begin errors++; $display("FAIL mid_busy_rst: got %b want 0", FetchBusy); end
    imem_ready = 1'b1; StallD = 1'b0;
    tick;
    reset = 1'b1;
  endtask

  task automatic test_wrap;
    tick;
    checks++; if (PCF !== 32'h0) begin errors++; $display("FAIL wrap_start: got %h want %h", PCF, 32'h0); end
    PCSrcD = 1'b1; PCBranchD = 32'hFFFF_FFFC;
    tick;
    PCSrcD = 1'b0; PCBranchD = 32'h0;
    checks++; if (PCF !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pcf: got %h want %h", PCF, 32'hFFFF_FFFC); end
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr: got %h want %h", imem_addr, 32'hFFFF_FFFC); end
    tick;
    checks++; if (PCF !== 32'h0) begin errors++; $display("FAIL wrap_pcf2: got %h want %h", PCF, 32'h0); end
    checks++; if (InstrD !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_instr: got %h want %h", InstrD, 32'hFFFF_FFFC); end
    checks++; if (PCPlus4D !== 32'h0) begin errors++; $display("FAIL wrap_pc4: got %h want %h", PCPlus4D, 32'h0); end
    checks++; if (ValidD !== 1'b1) begin errors++; $display("FAIL wrap_valid: got %b want 1", ValidD); end
  endtask

  initial begin
    test_reset;
    test_sequential;
    test_wait;
    test_stall_skid;
    test_redirect_drop;
    test_flush_stall;
    test_redirect_fetch;
    test_reset_mid_wait;
    test_wrap;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the 5-stage pipelined MIPS plus the IF/ID pipeline register. Feeds decode (InstrD, PCPlus4D) and sits directly upstream of it.
- Owns PCF and drives a variable-latency instruction-memory req/ready handshake.
- Honours StallF/StallD/FlushD from the hazard unit and raises FetchBusy back to it when memory stalls.

Parameters:
RESET_PC, 32'h0000_0000, PCF value loaded on reset
NOP_INSTR, 32'h0000_0000, value written to InstrD on reset/flush

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
StallF  in  1  hold PCF, issue no new request
StallD  in  1  hold IF/ID register
FlushD  in  1  clear IF/ID register (bubble)
PCSrcD  in  1  redirect fetch to PCBranchD
PCBranchD  in  32  redirect target
imem_req  out  1  request valid
imem_addr  out  32  request address (= PCF, or the held address in WAIT/DROP)
imem_ready  in  1  request accepted; imem_rdata valid in the same cycle
imem_rdata  in  32  instruction word
PCF  out  32  current fetch PC
InstrD  out  32  decode-stage instruction
PCPlus4D  out  32  decode-stage PC+4
ValidD  out  1  InstrD holds a real instruction
FetchBusy  out  1  request outstanding and not yet complete

Behaviour:
- Reset (async, reset==0): PCF=RESET_PC, InstrD=NOP_INSTR, PCPlus4D=0, ValidD=0, imem_req=0, skid buffer empty, state=IDLE.
- FSM states: IDLE, FETCH, WAIT, DROP.
- IDLE:
  - imem_req=0.
  - Moves to FETCH on the next clock, so the first request goes out one cycle after reset deasserts.
- FETCH:
  - imem_req = !StallF && !skid_full; imem_addr=PCF.
  - req&&ready: data accepted this cycle, zero-wait.
  - req&&!ready: go to WAIT.
- WAIT:
  - imem_req=1; imem_addr held stable until ready. Req/addr never change while unaccepted.
  - ready: accept the data, go to FETCH.
  - PCSrcD&&!ready: latch PCBranchD into redirect_q, go to DROP.
- DROP:
  - imem_req=1, old address held.
  - On ready: discard the data, PCF<=redirect_q, go to FETCH.
- Accepted-data handling (non-discarded):
  - PCF<=PCF+4, modulo 2^32; wraps 32'hFFFF_FFFC -> 0.
  - StallD=0 and skid empty: InstrD<=rdata, PCPlus4D<=PCF+4, ValidD<=1.
  - StallD=1: capture {rdata, PCF+4} in a one-entry skid buffer. skid_full blocks new requests.
- Skid drain: in any cycle with skid_full && !StallD && !FlushD, IF/ID loads from skid and skid clears. This takes priority over new data; no request can be accepted while full.
- Redirect: PCSrcD in FETCH/IDLE, or with data arriving the same cycle:
  - PCF<=PCBranchD.
  - Same-cycle data is discarded.
  - Skid cleared.
- FlushD: InstrD<=NOP_INSTR, PCPlus4D<=0, ValidD<=0, skid cleared. Priority over StallD.
- StallD without FlushD: IF/ID holds all values.
- StallF: PCF holds, except on a redirect, which always wins.
- FetchBusy = (state==WAIT) || (state==DROP). Combinational.
- PCF, IF/ID and skid registers update only on clk, or on reset.

Decomposition:
- fetch_pkg holds:
  - fetch_state_t enum {IDLE, FETCH, WAIT, DROP}
  - NOP_INSTR and RESET_PC default constants
  - localparam PC_INC = 32'd4
- Sub-module if_id_reg: IF/ID register plus the one-entry skid buffer, with stall/flush/load inputs.
- fetch_stage keeps the FSM, PC logic and memory handshake.

Test Plan:
- Reset release, imem_ready tied 1, memory returns addr-as-data -> PCF 0,4,8,...; InstrD=0x0 then 0x4 one cycle behind; ValidD=1 from 2nd post-reset cycle.
- imem_ready low 3 cycles at PCF=0x8 -> imem_addr held 0x8, FetchBusy=1 for 3 cycles, then InstrD=0x8, PCF=0xC.
- StallD=1 for 2 cycles while data 0xC arrives -> InstrD holds the old value, no new req; StallD=0 -> InstrD=0xC from skid, next req addr 0x10.
- PCSrcD=1, PCBranchD=0x100, while WAIT at 0x10 -> DROP. Ready -> that data discarded; next imem_addr=0x100, InstrD=0x100 after accept.
- FlushD and StallD both high -> InstrD=0, ValidD=0.
- Reset asserted mid-WAIT -> all outputs return to reset values immediately; PCF=RESET_PC.
